// File: rtl/branch_ctrl_queue.sv
// In-order queue of branch resolution records sitting between dispatch and ROB commit.
// Entries are allocated in program order, resolved out of order by ROB id, and retired from the head.

module bcq_slot #(
    parameter int ROB_IDX   = 5,
    parameter int RES_PORTS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          we_i,
    input  logic [ROB_IDX-1:0]            wr_rob_id_i,
    input  logic                          clr_i,
    input  logic [RES_PORTS-1:0]          res_valid_i,
    input  logic [RES_PORTS*ROB_IDX-1:0]  res_rob_id_i,
    input  logic [RES_PORTS-1:0]          res_mispredict_i,
    input  logic [RES_PORTS*ADDR_W-1:0]   res_target_i,
    output logic                          valid_o,
    output logic                          resolved_o,
    output logic [ROB_IDX-1:0]            rob_id_o,
    output logic                          mispredict_o,
    output logic [ADDR_W-1:0]             target_o
);
    logic               valid_q, valid_d;
    logic               resolved_q, resolved_d;
    logic               mispred_q, mispred_d;
    logic [ROB_IDX-1:0] rob_id_q, rob_id_d;
    logic [ADDR_W-1:0]  target_q, target_d;

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        mispred_d  = mispred_q;
        rob_id_d   = rob_id_q;
        target_d   = target_q;
        // Match against the pre-edge state only; later ports override earlier ones.
        for (int p = 0; p < RES_PORTS; p++) begin
            if (res_valid_i[p] && valid_q && !resolved_q &&
                rob_id_q == res_rob_id_i[p*ROB_IDX +: ROB_IDX]) begin
                resolved_d = 1'b1;
                mispred_d  = res_mispredict_i[p];
                target_d   = res_target_i[p*ADDR_W +: ADDR_W];
            end
        end
        if (clr_i) begin
            valid_d    = 1'b0;
            resolved_d = 1'b0;
        end
        if (we_i) begin
            valid_d    = 1'b1;
            resolved_d = 1'b0;
            mispred_d  = 1'b0;
            rob_id_d   = wr_rob_id_i;
        end
        if (flush_i) begin
            valid_d    = 1'b0;
            resolved_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            resolved_q <= 1'b0;
            mispred_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            mispred_q  <= mispred_d;
        end
    end

    always_ff @(posedge clk) begin
        rob_id_q <= rob_id_d;
        target_q <= target_d;
    end

    assign valid_o      = valid_q;
    assign resolved_o   = resolved_q;
    assign rob_id_o     = rob_id_q;
    assign mispredict_o = mispred_q;
    assign target_o     = target_q;
endmodule

module branch_ctrl_queue #(
    parameter int DEPTH     = 8,
    parameter int ROB_IDX   = 5,
    parameter int ENQ_WIDTH = 2,
    parameter int RES_PORTS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ENQ_WIDTH-1:0]          enq_valid,
    input  logic [ENQ_WIDTH*ROB_IDX-1:0]  enq_rob_id,
    output logic                          enq_ready,
    input  logic [RES_PORTS-1:0]          res_valid,
    input  logic [RES_PORTS*ROB_IDX-1:0]  res_rob_id,
    input  logic [RES_PORTS-1:0]          res_mispredict,
    input  logic [RES_PORTS*ADDR_W-1:0]   res_target,
    output logic                          head_valid,
    output logic [ROB_IDX-1:0]            head_rob_id,
    output logic                          head_mispredict,
    output logic [ADDR_W-1:0]             head_target,
    input  logic                          deq,
    input  logic                          flush,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   free_slots;
    logic [PTR_W-1:0] n_enq;
    logic [ENQ_WIDTH-1:0] enq_fire;
    logic             deq_fire;
    logic [IDX_W-1:0] rd_idx;

    logic [DEPTH-1:0]              slot_we, slot_clr;
    logic [DEPTH-1:0][ROB_IDX-1:0] slot_wid;
    logic [DEPTH-1:0]              slot_vld, slot_res, slot_mis;
    logic [DEPTH-1:0][ROB_IDX-1:0] slot_id;
    logic [DEPTH-1:0][ADDR_W-1:0]  slot_tgt;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign free_slots = (PTR_W+1)'(DEPTH) - {1'b0, count};
    assign enq_ready  = free_slots >= (PTR_W+1)'(ENQ_WIDTH);
    assign rd_idx     = rd_ptr_q[IDX_W-1:0];

    assign head_valid      = slot_vld[rd_idx] & slot_res[rd_idx];
    assign head_rob_id     = slot_id[rd_idx];
    assign head_mispredict = slot_mis[rd_idx];
    assign head_target     = slot_tgt[rd_idx];

    assign enq_fire = (enq_ready && !flush) ? enq_valid : '0;
    assign deq_fire = deq && head_valid && !flush;

    always_comb begin
        logic [IDX_W-1:0] widx;
        widx     = '0;
        slot_we  = '0;
        slot_wid = '0;
        slot_clr = '0;
        n_enq    = '0;
        // Lanes are contiguous, so lane k always lands at wr_ptr+k (wrapping past DEPTH-1).
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (enq_fire[k]) begin
                widx           = wr_ptr_q[IDX_W-1:0] + IDX_W'(k);
                slot_we[widx]  = 1'b1;
                slot_wid[widx] = enq_rob_id[k*ROB_IDX +: ROB_IDX];
                n_enq          = n_enq + PTR_W'(1);
            end
        end
        if (deq_fire) slot_clr[rd_idx] = 1'b1;
        wr_ptr_d = wr_ptr_q + n_enq;
        rd_ptr_d = rd_ptr_q + PTR_W'(deq_fire);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        bcq_slot #(
            .ROB_IDX   (ROB_IDX),
            .RES_PORTS (RES_PORTS),
            .ADDR_W    (ADDR_W)
        ) u_slot (
            .clk              (clk),
            .rst              (rst),
            .flush_i          (flush),
            .we_i             (slot_we[s]),
            .wr_rob_id_i      (slot_wid[s]),
            .clr_i            (slot_clr[s]),
            .res_valid_i      (res_valid),
            .res_rob_id_i     (res_rob_id),
            .res_mispredict_i (res_mispredict),
            .res_target_i     (res_target),
            .valid_o          (slot_vld[s]),
            .resolved_o       (slot_res[s]),
            .rob_id_o         (slot_id[s]),
            .mispredict_o     (slot_mis[s]),
            .target_o         (slot_tgt[s])
        );
    end
endmodule
